// File: rtl/conv_mac_unit.sv
// conv_mac_unit
//
// Signed multiply-accumulate stage of the convolution engine. It pops one
// activation and one weight per cycle from two show-ahead FIFOs, accumulates
// KernelSize signed products, and offers the dot product downstream on a
// valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   aclr         synchronous active-high reset
//   Enable       permits popping; low freezes accumulation, state is kept
//   ActEmpty     activation FIFO empty flag
//   ActData      activation FIFO head word (signed)
//   ActPop       pops the activation FIFO head this cycle
//   WgtEmpty     weight FIFO empty flag
//   WgtData      weight FIFO head word (signed)
//   WgtPop       pops the weight FIFO head this cycle
//   Result       signed dot product, stable while ResultValid=1
//   ResultValid  Result available
//   ResultReady  downstream accepts Result
//   TapCount     products accumulated in the current window
//   Busy         high while accumulating or holding a result
module conv_mac_unit #(
  parameter int DataWidth  = 32,
  parameter int KernelSize = 9,
  parameter int AccWidth   = 2 * DataWidth + 4,
  localparam int TapWidth  = $clog2(KernelSize + 1)
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  Enable,
  input  logic                  ActEmpty,
  input  logic [DataWidth-1:0]  ActData,
  output logic                  ActPop,
  input  logic                  WgtEmpty,
  input  logic [DataWidth-1:0]  WgtData,
  output logic                  WgtPop,
  output logic [AccWidth-1:0]   Result,
  output logic                  ResultValid,
  input  logic                  ResultReady,
  output logic [TapWidth-1:0]   TapCount,
  output logic                  Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                        state;
  logic [AccWidth-1:0]           acc;
  logic                          fire;
  logic                          last_tap;
  logic signed [2*DataWidth-1:0] product;
  logic [AccWidth-1:0]           product_ext;
  logic [AccWidth-1:0]           acc_next;

  // NOTE: pops are combinational so the FIFOs retire their heads on the same
  // edge the product is accumulated; aclr is folded in so nothing is popped
  // during a cycle whose edge will discard the partial sum anyway.
  assign fire   = (state == ACCUM) && Enable && !ActEmpty && !WgtEmpty && !aclr;
  assign ActPop = fire;
  assign WgtPop = fire;
  assign Busy   = (state != IDLE);

  // Full-width signed product, sign-extended into the accumulator width.
  assign product     = $signed(ActData) * $signed(WgtData);
  assign product_ext = {{(AccWidth - 2*DataWidth){product[2*DataWidth-1]}}, product};
  assign acc_next    = acc + product_ext;
  assign last_tap    = (TapCount == TapWidth'(KernelSize - 1));

  always_ff @(posedge clk) begin
    if (aclr) begin
      state       <= IDLE;
      acc         <= '0;
      TapCount    <= '0;
      Result      <= '0;
      ResultValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Enable) begin
            state    <= ACCUM;
            acc      <= '0;
            TapCount <= '0;
          end
        end

        ACCUM: begin
          // Any stall (Enable low or either FIFO empty) leaves everything as is.
          if (fire) begin
            if (last_tap) begin
              Result      <= acc_next;
              ResultValid <= 1'b1;
              state       <= HOLD;
              acc         <= '0;
              TapCount    <= '0;
            end else begin
              acc      <= acc_next;
              TapCount <= TapCount + 1'b1;
            end
          end
        end

        HOLD: begin
          // Result stays put until taken; Enable only decides where we go next.
          if (ResultValid && ResultReady) begin
            ResultValid <= 1'b0;
            state       <= Enable ? ACCUM : IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_unit.sv
// tb_conv_mac_unit
//
// Drives conv_mac_unit from two queue-backed show-ahead FIFO models and
// compares each dot product against values computed directly from the
// words pushed into the FIFOs.
module tb_conv_mac_unit;

  localparam int DW = 32;
  localparam int KS = 9;
  localparam int AW = 2 * DW + 4;
  localparam int TW = $clog2(KS + 1);

  logic          clk = 1'b0;
  logic          aclr;
  logic          Enable;
  logic          ActEmpty;
  logic [DW-1:0] ActData;
  logic          ActPop;
  logic          WgtEmpty;
  logic [DW-1:0] WgtData;
  logic          WgtPop;
  logic [AW-1:0] Result;
  logic          ResultValid;
  logic          ResultReady;
  logic [TW-1:0] TapCount;
  logic          Busy;

  conv_mac_unit #(.DataWidth(DW), .KernelSize(KS), .AccWidth(AW)) dut (
    .clk(clk), .aclr(aclr), .Enable(Enable),
    .ActEmpty(ActEmpty), .ActData(ActData), .ActPop(ActPop),
    .WgtEmpty(WgtEmpty), .WgtData(WgtData), .WgtPop(WgtPop),
    .Result(Result), .ResultValid(ResultValid), .ResultReady(ResultReady),
    .TapCount(TapCount), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Control knobs applied at the next step.
  logic rst, en, rdy, a_stall, w_stall;

  // FIFO contents.
  logic [DW-1:0] act_q[$];
  logic [DW-1:0] wgt_q[$];

  // Window staging arrays.
  logic [DW-1:0] wa[KS];
  logic [DW-1:0] ww[KS];

  // Values sampled in the last step.
  logic          s_pop, s_valid, s_busy;
  logic [AW-1:0] s_result;
  logic [TW-1:0] s_tap;
  int            s_cyc;
  int            cyc;

  int checks;
  int errors;

  // Reference dot product computed with plain wide signed arithmetic.
  function automatic logic [AW-1:0] dot_ref(input logic [DW-1:0] a[KS], input logic [DW-1:0] w[KS]);
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] ae;
    logic signed [AW-1:0] we;
    sum = '0;
    for (int i = 0; i < KS; i++) begin
      ae  = $signed(a[i]);
      we  = $signed(w[i]);
      sum = sum + ae * we;
    end
    return sum;
  endfunction

  task automatic push_window();
    for (int i = 0; i < KS; i++) begin
      act_q.push_back(wa[i]);
      wgt_q.push_back(ww[i]);
    end
  endtask

  // One clock cycle: drive at negedge, sample, then let the FIFO model
  // retire its heads on the rising edge if the DUT popped.
  task automatic step();
    @(negedge clk);
    aclr        = rst;
    Enable      = en;
    ResultReady = rdy;
    ActEmpty    = (act_q.size() == 0) || a_stall;
    WgtEmpty    = (wgt_q.size() == 0) || w_stall;
    ActData     = (act_q.size() != 0) ? act_q[0] : DW'($urandom);
    WgtData     = (wgt_q.size() != 0) ? wgt_q[0] : DW'($urandom);
    #1;
    s_pop    = ActPop;
    s_valid  = ResultValid;
    s_result = Result;
    s_tap    = TapCount;
    s_busy   = Busy;
    s_cyc    = cyc;
    checks++;
    if (ActPop !== WgtPop) begin
      errors++;
      $display("FAIL pop_pair cyc=%0d ActPop=%b WgtPop=%b expected equal", cyc, ActPop, WgtPop);
    end
    checks++;
    if (ActPop === 1'b1 && (ActEmpty || WgtEmpty || !Enable || aclr)) begin
      errors++;
      $display("FAIL pop_blocked cyc=%0d ActPop=1 expected 0 (empty=%b/%b en=%b aclr=%b)",
               cyc, ActEmpty, WgtEmpty, Enable, aclr);
    end
    @(posedge clk);
    if (s_pop === 1'b1) begin
      if (act_q.size() != 0) void'(act_q.pop_front());
      if (wgt_q.size() != 0) void'(wgt_q.pop_front());
    end
    cyc++;
  endtask

  // Runs until ResultValid is seen, optionally stalling once after
  // stall_at pops. kind: 0 none, 1 weight FIFO empty, 2 Enable low.
  task automatic run_window(input int stall_at, input int stall_len, input int kind,
                            output int pops, output int first_pop, output int last_pop,
                            output int valid_at, output int stall_bad);
    int stalled;
    logic stalling;
    pops = 0; first_pop = -1; last_pop = -1; valid_at = -1; stall_bad = 0; stalled = 0;
    for (int n = 0; n < 100 && valid_at < 0; n++) begin
      stalling = (kind != 0) && (pops == stall_at) && (stalled < stall_len);
      w_stall  = stalling && (kind == 1);
      en       = !(stalling && (kind == 2));
      step();
      if (stalling) begin
        stalled++;
        if (s_pop !== 1'b0 || s_tap !== TW'(stall_at)) stall_bad++;
      end
      if (s_valid === 1'b1) valid_at = s_cyc;
      else if (s_pop === 1'b1) begin
        pops++;
        if (first_pop < 0) first_pop = s_cyc;
        last_pop = s_cyc;
      end
    end
    w_stall = 1'b0;
    en      = 1'b1;
    checks++;
    if (valid_at < 0) begin
      errors++;
      $display("FAIL window_timeout no ResultValid within 100 cycles");
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < KS; i++) begin wa[i] = DW'(i + 7); ww[i] = DW'(2); end
    push_window();
    rst = 1'b1; en = 1'b1; rdy = 1'b1;
    step();
    step();
    checks++;
    if (s_pop !== 1'b0) begin
      errors++; $display("FAIL reset_pop ActPop=%b expected 0", s_pop);
    end
    checks++;
    if (s_valid !== 1'b0 || s_tap !== '0 || s_busy !== 1'b0 || s_result !== '0) begin
      errors++;
      $display("FAIL reset_state valid=%b tap=%0d busy=%b result=%h expected 0/0/0/0",
               s_valid, s_tap, s_busy, s_result);
    end
    act_q.delete();
    wgt_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int pops, fp, lp, va, sb;
    for (int i = 0; i < KS; i++) begin wa[i] = DW'(i + 1); ww[i] = DW'(1); end
    push_window();
    run_window(0, 0, 0, pops, fp, lp, va, sb);
    checks++;
    if (pops != KS || lp - fp != KS - 1) begin
      errors++; $display("FAIL basic_pops got %0d pops over %0d cycles expected %0d consecutive", pops, lp - fp + 1, KS);
    end
    checks++;
    if (va != lp + 1) begin
      errors++; $display("FAIL basic_latency valid at %0d expected %0d", va, lp + 1);
    end
    checks++;
    if (s_result !== AW'(45)) begin
      errors++; $display("FAIL basic_result got %0d expected 45", s_result);
    end
    checks++;
    if (s_tap !== '0 || s_busy !== 1'b1) begin
      errors++; $display("FAIL basic_hold tap=%0d busy=%b expected 0/1", s_tap, s_busy);
    end
  endtask

  task automatic test_signed();
    int pops, fp, lp, va, sb;
    logic [AW-1:0] exp;
    for (int i = 0; i < KS; i++) begin wa[i] = -DW'(2); ww[i] = DW'(3); end
    push_window();
    run_window(0, 0, 0, pops, fp, lp, va, sb);
    exp = -54;
    checks++;
    if (s_result !== exp) begin
      errors++; $display("FAIL signed_neg got %h expected %h", s_result, exp);
    end
    for (int i = 0; i < KS; i++) begin wa[i] = 32'h8000_0000; ww[i] = 32'h8000_0000; end
    push_window();
    run_window(0, 0, 0, pops, fp, lp, va, sb);
    exp = AW'(9) << 62;
    checks++;
    if (s_result !== exp) begin
      errors++; $display("FAIL signed_min got %h expected %h", s_result, exp);
    end
  endtask

  task automatic test_stall(input int kind, input int at, input int len, input string name);
    int pops, fp, lp, va, sb;
    logic [AW-1:0] exp;
    for (int i = 0; i < KS; i++) begin wa[i] = DW'($urandom); ww[i] = DW'($urandom); end
    exp = dot_ref(wa, ww);
    push_window();
    run_window(at, len, kind, pops, fp, lp, va, sb);
    checks++;
    if (sb != 0) begin
      errors++; $display("FAIL %s_hold %0d stall cycles popped or moved TapCount, expected 0", name, sb);
    end
    checks++;
    if (va - fp != KS + len) begin
      errors++; $display("FAIL %s_latency valid %0d cycles after first pop expected %0d", name, va - fp, KS + len);
    end
    checks++;
    if (s_result !== exp) begin
      errors++; $display("FAIL %s_result got %h expected %h", name, s_result, exp);
    end
  endtask

  task automatic test_backpressure();
    int pops, fp, lp, va, sb;
    logic [AW-1:0] exp;
    for (int i = 0; i < KS; i++) begin wa[i] = DW'($urandom); ww[i] = DW'($urandom_range(0, 15)); end
    exp = dot_ref(wa, ww);
    push_window();
    rdy = 1'b0;
    run_window(0, 0, 0, pops, fp, lp, va, sb);
    for (int i = 0; i < KS; i++) begin wa[i] = DW'(i + 10); ww[i] = DW'(1); end
    push_window();
    for (int n = 0; n < 5; n++) begin
      en = n[0];
      step();
      checks++;
      if (s_valid !== 1'b1 || s_result !== exp || s_pop !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d valid=%b result=%h pop=%b expected 1/%h/0", s_cyc, s_valid, s_result, s_pop, exp);
      end
    end
    en = 1'b1; rdy = 1'b1;
    step();
    checks++;
    if (s_valid !== 1'b1 || s_pop !== 1'b0) begin
      errors++; $display("FAIL bp_accept valid=%b pop=%b expected 1/0", s_valid, s_pop);
    end
    step();
    checks++;
    if (s_valid !== 1'b0 || s_pop !== 1'b1) begin
      errors++; $display("FAIL bp_resume valid=%b pop=%b expected 0/1", s_valid, s_pop);
    end
    run_window(0, 0, 0, pops, fp, lp, va, sb);
    checks++;
    if (s_result !== AW'(126)) begin
      errors++; $display("FAIL bp_second got %0d expected 126", s_result);
    end
  endtask

  task automatic test_reset_mid();
    int pops, fp, lp, va, sb;
    int taps;
    logic [AW-1:0] exp;
    for (int i = 0; i < KS; i++) begin wa[i] = DW'($urandom); ww[i] = DW'($urandom); end
    push_window();
    taps = 0;
    for (int n = 0; n < 50 && taps < 5; n++) begin
      step();
      if (s_pop === 1'b1) taps++;
    end
    rst = 1'b1;
    step();
    checks++;
    if (s_pop !== 1'b0) begin
      errors++; $display("FAIL rstmid_pop ActPop=%b expected 0 during aclr", s_pop);
    end
    rst = 1'b0;
    step();
    checks++;
    if (s_tap !== '0 || s_valid !== 1'b0 || s_busy !== 1'b0 || s_pop !== 1'b0 || s_result !== '0) begin
      errors++;
      $display("FAIL rstmid_state tap=%0d valid=%b busy=%b pop=%b result=%h expected 0/0/0/0/0",
               s_tap, s_valid, s_busy, s_pop, s_result);
    end
    act_q.delete();
    wgt_q.delete();
    for (int i = 0; i < KS; i++) begin wa[i] = DW'($urandom); ww[i] = DW'($urandom); end
    exp = dot_ref(wa, ww);
    push_window();
    run_window(0, 0, 0, pops, fp, lp, va, sb);
    checks++;
    if (s_result !== exp) begin
      errors++; $display("FAIL rstmid_fresh got %h expected %h", s_result, exp);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp;
    int got;
    got = 0;
    act_q.delete();
    wgt_q.delete();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < KS; i++) begin
        wa[i] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : DW'($urandom);
        ww[i] = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : DW'($urandom);
      end
      exp_q.push_back(dot_ref(wa, ww));
      push_window();
    end
    for (int n = 0; n < 2000 && got < 6; n++) begin
      a_stall = ($urandom_range(0, 3) == 0);
      w_stall = ($urandom_range(0, 3) == 0);
      en      = ($urandom_range(0, 4) != 0);
      rdy     = ($urandom_range(0, 2) != 0);
      step();
      if (s_valid === 1'b1 && rdy) begin
        exp = exp_q.pop_front();
        got++;
        checks++;
        if (s_result !== exp) begin
          errors++; $display("FAIL random_result #%0d got %h expected %h", got, s_result, exp);
        end
      end
    end
    a_stall = 1'b0; w_stall = 1'b0; en = 1'b1; rdy = 1'b1;
    checks++;
    if (got != 6) begin
      errors++; $display("FAIL random_timeout accepted %0d results expected 6", got);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; en = 1'b0; rdy = 1'b0; a_stall = 1'b0; w_stall = 1'b0;
    aclr = 1'b1; Enable = 1'b0; ResultReady = 1'b0;
    ActEmpty = 1'b1; WgtEmpty = 1'b1; ActData = '0; WgtData = '0;
    test_reset();
    test_basic();
    test_signed();
    test_stall(1, 4, 3, "empty_stall");
    test_stall(2, 6, 4, "enable_pause");
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_mac_unit.md
Name: conv_mac_unit

Overview:
Downstream consumer of the dual-output FIFO buffer stage in the convolution engine. Pops one activation and one weight per cycle from two show-ahead FIFO ports, multiplies them as signed values, and accumulates KernelSize products. It then presents the dot-product result on a valid/ready output to the next stage, which is the output writer or activation stage.

Parameters:
DataWidth, 32, width of activation and weight words (signed two's complement)
KernelSize, 9, taps accumulated per result (>=2)
AccWidth, 68, accumulator/result width (2*DataWidth+4; wraps modulo 2^AccWidth)

Ports:
clk  input  1  clock, all logic on rising edge
aclr  input  1  synchronous active-high reset
Enable  input  1  permits popping; low freezes accumulation without losing state
ActEmpty  input  1  activation FIFO empty flag
ActData  input  DataWidth  activation FIFO head word (valid when ActEmpty=0)
ActPop  output  1  pops activation FIFO head this cycle
WgtEmpty  input  1  weight FIFO empty flag
WgtData  input  DataWidth  weight FIFO head word (valid when WgtEmpty=0)
WgtPop  output  1  pops weight FIFO head this cycle
Result  output  AccWidth  signed dot product, stable while ResultValid=1
ResultValid  output  1  Result available
ResultReady  input  1  downstream accepts Result
TapCount  output  $clog2(KernelSize+1)  products accumulated in current window
Busy  output  1  high in ACCUM or HOLD

Behaviour:
- Reset (aclr=1 at rising edge) values: state IDLE, accumulator 0, TapCount 0, Result 0, ResultValid 0, Busy 0. ActPop/WgtPop are 0 combinationally while aclr=1. Reset mid-window discards partial sum; popped words are not restored.
- FIFO contract is show-ahead: data is valid when Empty=0; Pop consumes at the edge.
- Fire = (state==ACCUM) & Enable & ~ActEmpty & ~WgtEmpty & ~aclr.
- ActPop = WgtPop = Fire, combinational, always asserted together. Never pop one side alone.
- On Fire edge: acc <= acc + sext(ActData*WgtData), the full 2*DataWidth signed product sign-extended to AccWidth; TapCount+1.
- States:
  - IDLE: no pops. Go to ACCUM when Enable=1, with acc and TapCount cleared.
  - ACCUM: Fire accumulates. Enable=0 or either FIFO empty stalls with no state change. On the Fire edge where TapCount==KernelSize-1:
    - Result <= acc + final product.
    - ResultValid <= 1; state HOLD; acc and TapCount <= 0.
    - Latency: ResultValid rises the cycle after the last pop.
  - HOLD: no pops; Result and ResultValid held stable regardless of Enable. When ResultValid & ResultReady at an edge: ResultValid <= 0; next state is ACCUM if Enable=1, else IDLE.
    - Pops resume at the earliest the cycle after acceptance, so throughput is one result per KernelSize+1 cycles best case.
- Busy = (state != IDLE).
- Overflow: accumulator wraps silently. The default width cannot overflow for KernelSize <= 16.
- ResultReady is ignored outside HOLD. Enable low during HOLD does not drop ResultValid.

Test Plan:
- Basic dot product: Act 1..9, Wgt all 1, FIFOs never empty, Enable=1, ResultReady=1 → Pops high 9 consecutive cycles; ResultValid one cycle later; Result=45; TapCount back to 0.
- Signed: Act=-2, Wgt=3 for 9 taps → Result=-54 (sign-extended, all upper bits 1). Act=-2^31, Wgt=-2^31 ×9 → Result=9×2^62 with no wrap.
- Empty stall: WgtEmpty=1 for 3 cycles after tap 4 → no pops, TapCount holds 4; completes with result unchanged vs. unstalled run, ResultValid delayed by 3 cycles.
- Backpressure: ResultReady=0 for 5 cycles in HOLD → ResultValid and Result stable, zero pops. After ResultReady=1, next window starts the following cycle; second window Act 10..18 × Wgt 1 gives Result=126.
- Enable pause: Enable=0 after tap 6 for 4 cycles → no pops, acc retained; Result identical to uninterrupted run.
- Reset mid-window: aclr=1 at tap 5 → next cycle state IDLE, TapCount 0, ResultValid 0, no pops. A fresh window after Enable yields a result from new data only.
